// File: rtl/ula_src_control.sv
// ula_src_control
//   Multicycle control FSM for the ALU operand muxes, the ALU operation and
//   the PC/IR/memory/register-file strobes. Each instruction runs
//   FETCH -> DECODE -> EXEC -> MEM/WB. Memory accesses hold their strobe for
//   MEM_WAIT+1 cycles. Illegal opcodes and functs trap into a sticky
//   EXCEPTION state, which only reset leaves.
//
//   clk, reset (sync, active-low)   clock / reset
//   opcode, funct                   IR fields, stable from DECODE to next FETCH
//   zero                            ALU zero flag, used in BRANCH
//   alu_srca_sel, alu_srcb_sel      operand muxes (B: 00 rt, 01 4, 10 off, 11 off<<2)
//   alu_op                          000 none, 001 add, 010 sub, 011 and, 100 or
//   pc_write, pc_src                PC load and source (00 ALU, 01 ALUOut, 10 jump)
//   ir_write, aluout_write          IR / ALUOut load enables
//   mem_rd, mem_wr                  memory strobes
//   reg_write, reg_dst, mem_to_reg  register-file write controls
//   exc                             sticky illegal-instruction trap
//   state_dbg                       current state code
module ula_src_control #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alu_srca_sel,
  output logic [1:0] alu_srcb_sel,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_I      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_RD    = 4'd7,
    S_MEM_WR    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_EXCEPTION = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       wait_done;

  assign wait_done = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    alu_srca_sel = 1'b0;
    alu_srcb_sel = 2'b00;
    alu_op       = 3'b000;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    exc          = 1'b0;
    state_dbg    = state_q;

    case (state_q)
      S_FETCH: begin
        mem_rd       = 1'b1;
        alu_srcb_sel = 2'b01;
        alu_op       = 3'b001;
        if (wait_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        alu_srcb_sel = 2'b11;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_EXCEPTION;
        endcase
      end
      S_EXEC_R: begin
        alu_srca_sel = 1'b1;
        aluout_write = 1'b1;
        state_d      = S_WB_R;
        case (funct)
          6'h20:   alu_op = 3'b001;
          6'h22:   alu_op = 3'b010;
          6'h24:   alu_op = 3'b011;
          6'h25:   alu_op = 3'b100;
          default: begin
            aluout_write = 1'b0;
            state_d      = S_EXCEPTION;
          end
        endcase
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'b10;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
        state_d      = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'b10;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_EXCEPTION;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        if (wait_done) state_d = S_WB_MEM;
        else           wait_cnt_d = wait_cnt_q + 3'd1;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        if (wait_done) state_d = S_FETCH;
        else           wait_cnt_d = wait_cnt_q + 3'd1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_srca_sel = 1'b1;
        alu_op       = 3'b010;
        pc_src       = 2'b01;
        pc_write     = (opcode == OP_BNE) ? ~zero : zero;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
      S_EXCEPTION: begin
        exc = 1'b1;
      end
      default: begin
        state_d = S_EXCEPTION;
      end
    endcase

    // Reset blanks every output in the same cycle, not just from the next edge.
    if (!reset) begin
      alu_srca_sel = 1'b0;
      alu_srcb_sel = 2'b00;
      alu_op       = 3'b000;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      aluout_write = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      exc          = 1'b0;
      state_dbg    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_ula_src_control.sv
// tb_ula_src_control
//   Directed-vector bench for ula_src_control. Two instances share stimulus:
//   dut2 with MEM_WAIT=2 and dut0 with MEM_WAIT=0. All outputs of an instance
//   are packed into one vector and compared against hand-written expectations
//   each cycle.
module tb_ula_src_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       sa2, sa0;
  logic [1:0] sb2, sb0;
  logic [2:0] op2, op0;
  logic       pcw2, pcw0;
  logic [1:0] pcs2, pcs0;
  logic       irw2, irw0, aow2, aow0, mrd2, mrd0, mwr2, mwr0;
  logic       rw2, rw0, rd2, rd0, m2r2, m2r0, exc2, exc0;
  logic [3:0] st2, st0;

  ula_src_control #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_srca_sel(sa2), .alu_srcb_sel(sb2), .alu_op(op2), .pc_write(pcw2),
    .pc_src(pcs2), .ir_write(irw2), .aluout_write(aow2), .mem_rd(mrd2),
    .mem_wr(mwr2), .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2),
    .exc(exc2), .state_dbg(st2)
  );

  ula_src_control #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_srca_sel(sa0), .alu_srcb_sel(sb0), .alu_op(op0), .pc_write(pcw0),
    .pc_src(pcs0), .ir_write(irw0), .aluout_write(aow0), .mem_rd(mrd0),
    .mem_wr(mwr0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .exc(exc0), .state_dbg(st0)
  );

  always #5 clk = ~clk;

  // {state, srca, srcb, op, pc_write, pc_src, ir_write, aluout_write,
  //  mem_rd, mem_wr, reg_write, reg_dst, mem_to_reg, exc}
  logic [31:0] obs2, obs0;
  assign obs2 = {11'd0, st2, sa2, sb2, op2, pcw2, pcs2, irw2, aow2,
                 mrd2, mwr2, rw2, rd2, m2r2, exc2};
  assign obs0 = {11'd0, st0, sa0, sb0, op0, pcw0, pcs0, irw0, aow0,
                 mrd0, mwr0, rw0, rd0, m2r0, exc0};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [31:0] ev(input int st, input int sa, input int sb,
                                     input int op, input int pcw, input int pcs,
                                     input int irw, input int aow, input int mrd,
                                     input int mwr, input int rw, input int rd,
                                     input int m2r, input int ex);
    return {11'd0, 4'(st), 1'(sa), 2'(sb), 3'(op), 1'(pcw), 2'(pcs), 1'(irw),
            1'(aow), 1'(mrd), 1'(mwr), 1'(rw), 1'(rd), 1'(m2r), 1'(ex)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] f_mid, f_end, dec, all0;

  // Reset both instances for one edge; leaves the bench in the first FETCH cycle.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    step();
    check({tag, "_rst2"}, obs2, all0);
    check({tag, "_rst0"}, obs0, all0);
    reset = 1'b1;
    #1;
  endtask

  // Three-cycle fetch on dut2 starting from its first FETCH cycle; ends in DECODE.
  task automatic fetch2(input string tag);
    check({tag, "_f0"}, obs2, f_mid);
    step();
    check({tag, "_f1"}, obs2, f_mid);
    step();
    check({tag, "_f2"}, obs2, f_end);
    step();
    check({tag, "_dec"}, obs2, dec);
  endtask

  initial begin
    f_mid = ev(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    f_end = ev(0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    dec   = ev(1, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    all0  = '0;
    reset  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;
    #2;
    check("rst_comb", obs2, all0);

    // 1: R-type add
    do_reset("t1");
    fetch2("t1");
    step();
    check("t1_exec_r", obs2, ev(2, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step();
    check("t1_wb_r", obs2, ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step();
    check("t1_refetch", obs2, f_mid);

    // 2: lw, continuing from FETCH
    opcode = 6'h23;
    fetch2("t2");
    step();
    check("t2_memaddr", obs2, ev(6, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t2_memrd%0d", i), obs2,
            ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    end
    step();
    check("t2_wb_mem", obs2, ev(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step();

    // 3: beq / bne with zero=1
    opcode = 6'h04;
    zero   = 1'b1;
    fetch2("t3a");
    step();
    check("t3_beq", obs2, ev(10, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    opcode = 6'h05;
    fetch2("t3b");
    step();
    check("t3_bne", obs2, ev(10, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check("t3_back", obs2, f_mid);

    // 4: illegal opcode, then illegal funct
    opcode = 6'h3F;
    fetch2("t4a");
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("t4_exc%0d", i), obs2,
            ev(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    opcode = 6'h00;
    funct  = 6'h2A;
    do_reset("t4b");
    fetch2("t4b");
    step();
    check("t4_exec_bad", obs2, ev(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t4_fexc%0d", i), obs2,
            ev(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    do_reset("t4c");
    check("t4_clear", obs2, f_mid);

    // 5: reset asserted during the 2nd MEM_RD wait cycle
    funct  = 6'h20;
    opcode = 6'h23;
    do_reset("t5a");
    fetch2("t5");
    step();
    step();
    check("t5_memrd0", obs2, ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    check("t5_memrd1", obs2, ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    check("t5_rst_mid", obs2, all0);
    do_reset("t5b");
    fetch2("t5r");

    // 6: addi on the MEM_WAIT=0 instance
    opcode = 6'h08;
    do_reset("t6");
    check("t6_fetch", obs0, f_end);
    step();
    check("t6_dec", obs0, dec);
    step();
    check("t6_exec_i", obs0, ev(4, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step();
    check("t6_wb_i", obs0, ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step();
    check("t6_refetch", obs0, f_end);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
